// File: rtl/pipe_ctrl_regs.sv
// Pipeline register bank with stall/flush control for the RV32I core.
// Optional perf counters are built when PIPE_PERF_CNT_EN is defined.
module pipe_ctrl_regs #(
  parameter int WIDTH        = 64,
  parameter int NUM_STAGES   = 4,
  parameter int HAZARD_STAGE = 1,
  parameter int FLUSH_STAGE  = 2,
  parameter int MEM_STAGE    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_STAGES*WIDTH-1:0] stage_d,
  output logic [NUM_STAGES*WIDTH-1:0] stage_q,
  output logic [NUM_STAGES-1:0]       stage_v,
  input  logic                        imem_resp,
  input  logic                        mem_req,
  input  logic                        dmem_resp,
  input  logic                        hazard_stall,
  input  logic                        redirect,
  output logic                        load_pc,
  output logic [31:0]                 perf_stall_cnt,
  output logic [31:0]                 perf_flush_cnt
);

  generate
    if (!(HAZARD_STAGE >= 1 && HAZARD_STAGE < FLUSH_STAGE &&
          FLUSH_STAGE < MEM_STAGE && MEM_STAGE <= NUM_STAGES - 1)) begin : g_bad_params
      $error("pipe_ctrl_regs: need 1 <= HAZARD_STAGE < FLUSH_STAGE < MEM_STAGE <= NUM_STAGES-1");
    end
  endgenerate

  logic [NUM_STAGES*WIDTH-1:0] data_p0;
  logic [NUM_STAGES-1:0]       vld_p0;
  logic [NUM_STAGES-1:0]       vld_prev;
  logic                        mem_stall;
  logic                        haz;
  logic                        flush;

  // Every qualifier is gated on the valid bit of the stage that raises it.
  assign mem_stall = mem_req & vld_p0[MEM_STAGE-1] & ~dmem_resp;
  assign haz       = hazard_stall & vld_p0[HAZARD_STAGE-1] & ~mem_stall;
  assign flush     = redirect & vld_p0[FLUSH_STAGE-1] & ~mem_stall;

  assign vld_prev  = {vld_p0[NUM_STAGES-2:0], 1'b0};
  assign load_pc   = ~rst & (flush | (imem_resp & ~mem_stall & ~haz));

  // ---- register stage: per-register hold / bubble / advance ----
  always_ff @(posedge clk) begin
    if (rst) begin
      data_p0 <= '0;
      vld_p0  <= '0;
    end else begin
      for (int k = 0; k < NUM_STAGES; k++) begin
        if (mem_stall) begin
          if (k == MEM_STAGE) begin
            data_p0[k*WIDTH +: WIDTH] <= '0;
            vld_p0[k]                 <= 1'b0;
          end else if (k > MEM_STAGE) begin
            data_p0[k*WIDTH +: WIDTH] <= stage_d[k*WIDTH +: WIDTH];
            vld_p0[k]                 <= vld_prev[k];
          end
        end else if (flush) begin
          if (k < FLUSH_STAGE) begin
            data_p0[k*WIDTH +: WIDTH] <= '0;
            vld_p0[k]                 <= 1'b0;
          end else begin
            data_p0[k*WIDTH +: WIDTH] <= stage_d[k*WIDTH +: WIDTH];
            vld_p0[k]                 <= vld_prev[k];
          end
        end else if (haz) begin
          if (k == HAZARD_STAGE) begin
            data_p0[k*WIDTH +: WIDTH] <= '0;
            vld_p0[k]                 <= 1'b0;
          end else if (k > HAZARD_STAGE) begin
            data_p0[k*WIDTH +: WIDTH] <= stage_d[k*WIDTH +: WIDTH];
            vld_p0[k]                 <= vld_prev[k];
          end
        end else if (k == 0) begin
          data_p0[k*WIDTH +: WIDTH] <= imem_resp ? stage_d[k*WIDTH +: WIDTH] : '0;
          vld_p0[k]                 <= imem_resp;
        end else begin
          data_p0[k*WIDTH +: WIDTH] <= stage_d[k*WIDTH +: WIDTH];
          vld_p0[k]                 <= vld_prev[k];
        end
      end
    end
  end

  assign stage_q = data_p0;
  assign stage_v = vld_p0;

`ifdef PIPE_PERF_CNT_EN
  logic [31:0] stall_cnt_p0;
  logic [31:0] flush_cnt_p0;
  logic        stall_ev;

  function automatic logic [31:0] sat_inc(input logic [31:0] c);
    return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
  endfunction

  assign stall_ev = mem_stall | haz | (~imem_resp & ~flush);

  // ---- counter stage ----
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_p0 <= '0;
      flush_cnt_p0 <= '0;
    end else begin
      if (stall_ev) stall_cnt_p0 <= sat_inc(stall_cnt_p0);
      if (flush)    flush_cnt_p0 <= sat_inc(flush_cnt_p0);
    end
  end

  assign perf_stall_cnt = stall_cnt_p0;
  assign perf_flush_cnt = flush_cnt_p0;
`else
  assign perf_stall_cnt = '0;
  assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_regs.sv
// Directed table-driven bench for pipe_ctrl_regs (default 4-stage configuration).
module tb_pipe_ctrl_regs;
  localparam int W = 64;
  localparam int N = 4;
`ifdef PIPE_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] stage_d;
  logic [N*W-1:0] stage_q;
  logic [N-1:0]   stage_v;
  logic           imem_resp, mem_req, dmem_resp, hazard_stall, redirect;
  logic           load_pc;
  logic [31:0]    perf_stall_cnt, perf_flush_cnt;
  logic [W-1:0]   d0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Stage logic around the bank is modelled as a straight pass-through.
  assign stage_d[0 +: W] = d0;
  for (genvar g = 1; g < N; g++) begin : g_pass
    assign stage_d[g*W +: W] = stage_q[(g-1)*W +: W];
  end

  pipe_ctrl_regs dut (
    .clk(clk), .rst(rst), .stage_d(stage_d), .stage_q(stage_q), .stage_v(stage_v),
    .imem_resp(imem_resp), .mem_req(mem_req), .dmem_resp(dmem_resp),
    .hazard_stall(hazard_stall), .redirect(redirect), .load_pc(load_pc),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
  );

  typedef struct {
    logic       rst;
    logic [7:0] d0;
    logic       ir, mr, dr, hz, rd;
    logic       lpc;
    logic [3:0] v;
    logic [7:0] q0, q1, q2, q3;
    int         sc, fc;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic r, input logic [7:0] d, input logic ir, mr, dr, hz, rd,
                     input logic lpc, input logic [3:0] v,
                     input logic [7:0] q0, q1, q2, q3, input int sc, fc);
    vec_t e;
    e.rst = r; e.d0 = d; e.ir = ir; e.mr = mr; e.dr = dr; e.hz = hz; e.rd = rd;
    e.lpc = lpc; e.v = v; e.q0 = q0; e.q1 = q1; e.q2 = q2; e.q3 = q3;
    e.sc = sc; e.fc = fc;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic [7:0] d, input logic ir, mr, dr, hz, rd);
    @(negedge clk);
    rst = r; d0 = {56'd0, d}; imem_resp = ir; mem_req = mr;
    dmem_resp = dr; hazard_stall = hz; redirect = rd;
    #1;
  endtask

  task automatic after_edge();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] qk(input int k);
    return stage_q[k*W +: W];
  endfunction

  initial begin
    rst = 1'b1; d0 = '0; imem_resp = 1'b0; mem_req = 1'b0;
    dmem_resp = 1'b0; hazard_stall = 1'b0; redirect = 1'b0;

    //   rst d0     ir mr dr hz rd  lpc v        q0     q1     q2     q3     sc fc
    // reset
    row(1, 8'h00, 1, 0, 0, 0, 0,  0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    row(1, 8'h00, 1, 0, 0, 0, 0,  0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    // free run
    row(0, 8'h11, 1, 0, 0, 0, 0,  1, 4'b0001, 8'h11, 8'h00, 8'h00, 8'h00, 0, 0);
    row(0, 8'h22, 1, 0, 0, 0, 0,  1, 4'b0011, 8'h22, 8'h11, 8'h00, 8'h00, 0, 0);
    row(0, 8'h33, 1, 0, 0, 0, 0,  1, 4'b0111, 8'h33, 8'h22, 8'h11, 8'h00, 0, 0);
    row(0, 8'h44, 1, 0, 0, 0, 0,  1, 4'b1111, 8'h44, 8'h33, 8'h22, 8'h11, 0, 0);
    // dmem wait for 3 cycles, then release
    row(0, 8'h55, 1, 1, 0, 0, 0,  0, 4'b0111, 8'h44, 8'h33, 8'h22, 8'h00, 1, 0);
    row(0, 8'h55, 1, 1, 0, 0, 0,  0, 4'b0111, 8'h44, 8'h33, 8'h22, 8'h00, 2, 0);
    row(0, 8'h55, 1, 1, 0, 0, 0,  0, 4'b0111, 8'h44, 8'h33, 8'h22, 8'h00, 3, 0);
    row(0, 8'h55, 1, 1, 1, 0, 0,  1, 4'b1111, 8'h55, 8'h44, 8'h33, 8'h22, 3, 0);
    // load-use
    row(0, 8'h66, 1, 0, 0, 1, 0,  0, 4'b1101, 8'h55, 8'h00, 8'h44, 8'h33, 4, 0);
    row(0, 8'h66, 1, 0, 0, 0, 0,  1, 4'b1011, 8'h66, 8'h55, 8'h00, 8'h44, 4, 0);
    // flush beats hazard (haz still counts as a stall cycle)
    row(0, 8'h77, 1, 0, 0, 1, 1,  1, 4'b0100, 8'h00, 8'h00, 8'h55, 8'h00, 5, 1);
    // refill
    row(0, 8'h88, 1, 0, 0, 0, 0,  1, 4'b1001, 8'h88, 8'h00, 8'h00, 8'h55, 5, 1);
    row(0, 8'h99, 1, 0, 0, 0, 0,  1, 4'b0011, 8'h99, 8'h88, 8'h00, 8'h00, 5, 1);
    row(0, 8'hAA, 1, 0, 0, 0, 0,  1, 4'b0111, 8'hAA, 8'h99, 8'h88, 8'h00, 5, 1);
    // redirect during dmem wait is ignored, then taken on release
    row(0, 8'hBB, 1, 1, 0, 0, 1,  0, 4'b0111, 8'hAA, 8'h99, 8'h88, 8'h00, 6, 1);
    row(0, 8'hBB, 1, 1, 1, 0, 1,  1, 4'b1100, 8'h00, 8'h00, 8'h99, 8'h88, 6, 2);
    // imem wait
    row(0, 8'hCC, 0, 0, 0, 0, 0,  0, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h99, 7, 2);
    // reset with every request raised
    row(1, 8'hDD, 1, 1, 0, 1, 1,  0, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0);
    // requests from invalid stages are ignored
    row(0, 8'hEE, 1, 1, 0, 1, 1,  1, 4'b0001, 8'hEE, 8'h00, 8'h00, 8'h00, 0, 0);

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].d0, tbl[i].ir, tbl[i].mr, tbl[i].dr, tbl[i].hz, tbl[i].rd);
      chk($sformatf("row%0d load_pc", i), {63'd0, load_pc}, {63'd0, tbl[i].lpc});
      after_edge();
      chk($sformatf("row%0d stage_v", i), {60'd0, stage_v}, {60'd0, tbl[i].v});
      chk($sformatf("row%0d q0", i), qk(0), {56'd0, tbl[i].q0});
      chk($sformatf("row%0d q1", i), qk(1), {56'd0, tbl[i].q1});
      chk($sformatf("row%0d q2", i), qk(2), {56'd0, tbl[i].q2});
      chk($sformatf("row%0d q3", i), qk(3), {56'd0, tbl[i].q3});
      chk($sformatf("row%0d stall_cnt", i), {32'd0, perf_stall_cnt},
          PERF ? 64'(tbl[i].sc) : 64'd0);
      chk($sformatf("row%0d flush_cnt", i), {32'd0, perf_flush_cnt},
          PERF ? 64'(tbl[i].fc) : 64'd0);
    end

    // Reset arriving in the middle of a dmem stall leaves nothing held.
    drive(0, 8'hA1, 1, 0, 0, 0, 0); after_edge();
    drive(0, 8'hA2, 1, 0, 0, 0, 0); after_edge();
    chk("seq fill v", {60'd0, stage_v}, 64'h7);
    drive(0, 8'hA3, 1, 1, 0, 0, 0);
    chk("seq stall load_pc", {63'd0, load_pc}, 64'd0);
    after_edge();
    chk("seq stall v", {60'd0, stage_v}, 64'h7);
    chk("seq stall q2", qk(2), 64'hEE);
    drive(1, 8'hA3, 1, 1, 0, 0, 0);
    chk("seq rst load_pc", {63'd0, load_pc}, 64'd0);
    after_edge();
    chk("seq rst v", {60'd0, stage_v}, 64'h0);
    chk("seq rst q0", qk(0), 64'h0);
    chk("seq rst q2", qk(2), 64'h0);
    drive(0, 8'hB1, 1, 0, 0, 0, 0);
    chk("seq resume load_pc", {63'd0, load_pc}, 64'd1);
    after_edge();
    chk("seq resume v", {60'd0, stage_v}, 64'h1);
    chk("seq resume q0", qk(0), 64'hB1);
    chk("seq resume stall_cnt", {32'd0, perf_stall_cnt}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl_regs.md
Name: pipe_ctrl_regs

Overview:
- Parametrised pipeline-register bank and stall/flush controller for the RV32I core.
- Replaces the hard-wired four-register chain, which has no stall handling, with a chain of NUM_STAGES registers.
- Each register carries a uniform WIDTH payload plus a valid bit.
- Generates load_pc and applies imem-wait, dmem-wait, load-use hazard and branch-redirect flush rules.
- Sits at CPU top; stage combinational logic (fetch/decode/execute/mem/wb) connects around it.

Parameters:
- WIDTH, 64: payload bits per pipeline register.
- NUM_STAGES, 4: number of pipeline registers. Reg k is written by stage k and read by stage k+1. Stage 0 = IF, stage NUM_STAGES = WB.
- HAZARD_STAGE, 1: stage that raises the load-use stall (ID).
- FLUSH_STAGE, 2: stage that resolves branches (EX).
- MEM_STAGE, 3: stage that accesses dmem.
- Legal only if 1 <= HAZARD_STAGE < FLUSH_STAGE < MEM_STAGE <= NUM_STAGES-1. Elaboration error otherwise.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- stage_d  in  NUM_STAGES*WIDTH  next payload from stage k, in slice [k*WIDTH +: WIDTH].
- stage_q  out  NUM_STAGES*WIDTH  registered payloads, same slicing.
- stage_v  out  NUM_STAGES  registered valid bits.
- imem_resp  in  1  fetch data valid this cycle.
- mem_req  in  1  MEM stage issuing dmem read or write.
- dmem_resp  in  1  dmem access complete.
- hazard_stall  in  1  load-use stall request from HAZARD_STAGE.
- redirect  in  1  taken branch/jump in FLUSH_STAGE.
- load_pc  out  1  PC register write enable.
- perf_stall_cnt  out  32  see Optional Feature.
- perf_flush_cnt  out  32  see Optional Feature.

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset: all stage_q = 0, stage_v = 0, load_pc = 0 while rst is high. Counters = 0.
- Qualified internal terms:
  - mem_stall = mem_req & stage_v[MEM_STAGE-1] & ~dmem_resp.
  - haz = hazard_stall & stage_v[HAZARD_STAGE-1] & ~mem_stall.
  - flush = redirect & stage_v[FLUSH_STAGE-1] & ~mem_stall.
    - Redirect is ignored during mem_stall. The EX instruction is held, so it re-asserts redirect later.
- Per-register update, first matching rule wins, evaluated per k each cycle:
  1. mem_stall:
     - k < MEM_STAGE: hold.
     - k == MEM_STAGE: bubble.
     - k > MEM_STAGE: advance.
  2. flush:
     - k < FLUSH_STAGE: bubble.
     - k >= FLUSH_STAGE: advance.
     - Flush overrides haz and imem wait.
  3. haz:
     - k < HAZARD_STAGE: hold.
     - k == HAZARD_STAGE: bubble.
     - k > HAZARD_STAGE: advance.
  4. Otherwise:
     - k == 0: load stage_d[0] with v = imem_resp; bubble if ~imem_resp.
     - k > 0: advance.
- Action definitions:
  - advance: q[k] <= stage_d[k], v[k] <= v[k-1] (k>0).
  - hold: q and v unchanged.
  - bubble: q[k] <= 0, v[k] <= 0.
- load_pc (combinational) = ~rst & (flush | (imem_resp & ~mem_stall & ~haz)).
- Latency: one cycle per register. With no stalls, an instruction fetched at cycle t appears valid in reg k at edge t+k+1.
- Throughput: one instruction per cycle.
- Invalid stages: a stage with v=0 never raises a qualified stall or flush (all qualifiers above gate on valid).
- Reset mid-stall: rst overrides everything. No held state survives.

Optional Feature:
- Macro: PIPE_PERF_CNT_EN.
- Defined:
  - perf_stall_cnt increments on every cycle with mem_stall | haz | (~imem_resp & ~flush).
  - perf_flush_cnt increments on every cycle with flush.
  - Both counters saturate at 32'hFFFFFFFF and clear on rst.
- Undefined: counter logic is absent and both outputs are tied to 0.

Test Plan:
- Free run: rst high 2 cycles, then imem_resp=1 always, stage_d[0] = 0x11, 0x22, 0x33, ... -> stage_q[3] = 0x11 with stage_v[3]=1 at the 4th edge after reset release; load_pc=1 every cycle; load_pc=0 during rst.
- Dmem wait: valid load in reg 2, mem_req=1, dmem_resp=0 for 3 cycles -> regs 0..2 frozen for 3 cycles, reg 3 v=0 and q=0; load_pc=0. Release on dmem_resp=1 -> reg 3 = reg 2 payload, v=1.
- Load-use: hazard_stall=1 for 1 cycle with reg 0 valid -> reg 0 held, reg 1 bubble, regs 2..3 advance, load_pc=0.
- Branch flush: redirect=1 with reg 1 valid, hazard_stall=1 same cycle -> regs 0..1 become v=0, reg 2 advances; load_pc=1; flush beats hazard.
- Redirect during dmem wait: redirect=1 and mem_stall=1 same cycle -> no flush, regs 0..2 held; on the next cycle with dmem_resp=1 and redirect still 1 -> flush takes effect.
- With PIPE_PERF_CNT_EN defined: run the previous five scenarios -> perf_flush_cnt=2, perf_stall_cnt equals the counted stall cycles. Without the macro -> both outputs read 0 throughout.
